// File: rtl/pulse_train_generator.sv
// pulse_train_generator: programmable train of high pulses separated by low gaps, with done strobe
module pulse_train_generator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [CNT_W-1:0] gap_width,
  input  logic [CNT_W-1:0] pulse_count,
  input  logic             abort,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam logic [CNT_W-1:0] one = CNT_W'(1);
  state_t state, state_n;
  logic [CNT_W-1:0] phase, phase_n, rem, rem_n, width_q, width_n, gap_q, gap_n;
  logic [CNT_W-1:0] width_eff, gap_eff;
  logic done_n;
  assign width_eff = pulse_width == '0 ? one : pulse_width;
  assign gap_eff   = gap_width == '0 ? one : gap_width;
  // State, counters and outputs; outputs are registered from the next-state decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      rem       <= '0;
      width_q   <= '0;
      gap_q     <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      rem       <= rem_n;
      width_q   <= width_n;
      gap_q     <= gap_n;
      pulse_out <= state_n == HIGH;
      busy      <= state_n != IDLE;
      done      <= done_n;
    end
  end
  // Next-state: phase counter holds cycles left in the current phase, including this one
  always_comb begin
    state_n = state;
    phase_n = phase;
    rem_n   = rem;
    width_n = width_q;
    gap_n   = gap_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          width_n = width_eff;
          gap_n   = gap_eff;
          rem_n   = pulse_count;
          phase_n = width_eff;
          done_n  = pulse_count == '0;
          state_n = pulse_count == '0 ? IDLE : HIGH;
        end
      end
      HIGH: begin
        if (abort) state_n = IDLE;
        else if (phase == one) begin
          done_n  = rem == one;
          state_n = rem == one ? IDLE : LOW;
          phase_n = gap_q;
        end else phase_n = phase - one;
      end
      LOW: begin
        if (abort) state_n = IDLE;
        else if (phase == one) begin
          state_n = HIGH;
          phase_n = width_q;
          rem_n   = rem - one;
        end else phase_n = phase - one;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_pulse_train_generator.sv
// tb_pulse_train_generator: directed literal checks plus randomized run against a timeline model
module tb_pulse_train_generator;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] pulse_width = '0, gap_width = '0, pulse_count = '0;
  logic pulse_out, busy, done;
  int tests = 0, fails = 0;
  pulse_train_generator #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pulse_width(pulse_width), .gap_width(gap_width),
    .pulse_count(pulse_count), .abort(abort), .pulse_out(pulse_out), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  // Timeline model: a train accepted in cycle t0 is fully described by offset arithmetic
  int cyc = 0, t0 = 0, mw = 1, mg = 1, mn = 0;
  bit act = 0, chk = 0;
  logic exp_pulse = 0, exp_busy = 0, exp_done = 0;
  always @(posedge clk) begin
    int o, len;
    if (rst) act = 0;
    else if (exp_busy && abort) act = 0;
    else if (!exp_busy && start && !abort) begin
      act = 1;
      t0 = cyc;
      mw = pulse_width == 0 ? 1 : int'(pulse_width);
      mg = gap_width == 0 ? 1 : int'(gap_width);
      mn = int'(pulse_count);
    end
    cyc++;
    o = cyc - t0 - 1;
    len = mn * mw + (mn - 1) * mg;
    exp_busy = act && mn > 0 && o < len;
    exp_pulse = exp_busy && (o % (mw + mg)) < mw;
    exp_done = act && (mn == 0 ? o == 0 : o == len);
    chk = 1;
  end
  always @(negedge clk) begin
    if (chk) begin
      check("model pulse_out", int'(pulse_out), int'(exp_pulse));
      check("model busy", int'(busy), int'(exp_busy));
      check("model done", int'(done), int'(exp_done));
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start_train(input int w, input int g, input int n);
    pulse_width = 8'(w);
    gap_width = 8'(g);
    pulse_count = 8'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic capture(input int k, input int at, input logic s, input logic a, input logic r,
                         output logic [31:0] p, output logic [31:0] d, output logic [31:0] b);
    p = '0;
    d = '0;
    b = '0;
    for (int i = 0; i < k; i++) begin
      p = {p[30:0], pulse_out};
      d = {d[30:0], done};
      b = {b[30:0], busy};
      if (i == at) begin
        start = s;
        abort = a;
        rst = r;
      end
      tick();
      start = 1'b0;
      abort = 1'b0;
      rst = 1'b0;
    end
  endtask
  initial begin
    logic [31:0] p, d, b;
    int edges, hi;
    bit prev, seen;
    tick();
    tick();
    check("reset pulse_out", int'(pulse_out), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    rst = 1'b0;
    tick();
    start_train(1, 1, 3);
    capture(7, -1, 0, 0, 0, p, d, b);
    check("w1g1n3 pulse", int'(p), 'b1010100);
    check("w1g1n3 done", int'(d), 'b0000010);
    check("w1g1n3 busy", int'(b), 'b1111100);
    start_train(3, 2, 2);
    capture(10, -1, 0, 0, 0, p, d, b);
    check("w3g2n2 pulse", int'(p), 'b1110011100);
    check("w3g2n2 done", int'(d), 'b0000000010);
    edges = 0;
    prev = 0;
    for (int i = 9; i >= 0; i--) begin
      if (p[i] && !prev) edges++;
      prev = p[i];
    end
    check("w3g2n2 rising edges", edges, 2);
    start_train(0, 0, 2);
    capture(5, -1, 0, 0, 0, p, d, b);
    check("w0g0n2 pulse", int'(p), 'b10100);
    check("w0g0n2 done", int'(d), 'b00010);
    start_train(5, 5, 0);
    capture(3, -1, 0, 0, 0, p, d, b);
    check("n0 pulse", int'(p), 'b000);
    check("n0 busy", int'(b), 'b000);
    check("n0 done", int'(d), 'b100);
    start_train(2, 1, 2);
    pulse_width = 8'd5;
    gap_width = 8'd5;
    pulse_count = 8'd5;
    capture(7, 1, 1, 0, 0, p, d, b);
    check("start while busy pulse", int'(p), 'b1101100);
    check("start while busy done", int'(d), 'b0000010);
    start_train(1, 1, 1);
    pulse_width = 8'd2;
    pulse_count = 8'd1;
    capture(6, 1, 1, 0, 0, p, d, b);
    check("back-to-back pulse", int'(p), 'b101100);
    check("back-to-back busy", int'(b), 'b101100);
    check("back-to-back done", int'(d), 'b010010);
    start_train(4, 1, 2);
    capture(6, 1, 0, 1, 0, p, d, b);
    check("abort pulse", int'(p), 'b110000);
    check("abort busy", int'(b), 'b110000);
    check("abort done", int'(d), 'b000000);
    start_train(4, 1, 2);
    capture(8, 4, 0, 0, 1, p, d, b);
    check("rst mid-gap pulse", int'(p), 'b11110000);
    check("rst mid-gap busy", int'(b), 'b11111000);
    check("rst mid-gap done", int'(d), 'b00000000);
    start_train(1, 1, 3);
    capture(7, -1, 0, 0, 0, p, d, b);
    check("after rst pulse", int'(p), 'b1010100);
    check("after rst done", int'(d), 'b0000010);
    pulse_count = 8'd1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort+start idle busy", int'(busy), 0);
    check("abort+start idle done", int'(done), 0);
    tick();
    start_train(255, 1, 1);
    hi = 0;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (pulse_out) hi++;
      if (done) seen = 1;
      else tick();
    end
    check("w255 high cycles", hi, 255);
    check("w255 done seen", int'(seen), 1);
    tick();
    for (int i = 0; i < 4000; i++) begin
      start = $urandom_range(0, 3) == 0;
      pulse_width = 8'($urandom_range(0, 4));
      gap_width = 8'($urandom_range(0, 3));
      pulse_count = 8'($urandom_range(0, 3));
      abort = $urandom_range(0, 40) == 0;
      rst = $urandom_range(0, 150) == 0;
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
